// File: rtl/oled_spi_receiver.sv
// SPI receive end of the PmodOLED (SSD1331) link: decodes command bytes and RGB565 pixels, tags pixels with x,y.
// Optional statistics counters (abort_cnt, frame_cnt) are enabled by defining OLED_RX_STATS_EN.
`timescale 1ns/1ps
module oled_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [6:0]  pixel_x,
  output logic [5:0]  pixel_y,
  output logic        frame_done,
  output logic [15:0] abort_cnt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, COL_S, COL_E, ROW_S, ROW_E} parse_t;

  localparam logic [7:0] COL_MAX = 8'(WIDTH - 1);
  localparam logic [7:0] ROW_MAX = 8'(HEIGHT - 1);
  localparam logic [7:0] CMD_COL = 8'h15;
  localparam logic [7:0] CMD_ROW = 8'h75;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdin_sync, dc_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s, sdin_s, dc_s;
  logic                   sclk_rise, cs_rise, shift_en, abort_hit;

  // NOTE: cs synchronisers reset to the idle-high level so a released reset never looks like a selected bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      sdin_sync <= '0;
      dc_sync   <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the previous value of the one before it.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], d_cn};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign shift_en  = sclk_rise & ~cs_s;

  logic [6:0] sr;
  logic [2:0] bitcnt;
  logic       byte_rdy;
  logic [7:0] rx_byte;
  logic       rx_dc;

  // shift_en needs cs_s low and abort needs it high, so a completing byte can never be counted as aborted.
  assign abort_hit = cs_rise & (bitcnt != 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      bitcnt   <= '0;
      byte_rdy <= 1'b0;
      rx_byte  <= '0;
      rx_dc    <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      if (shift_en) begin
        sr     <= {sr[5:0], sdin_s};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          byte_rdy <= 1'b1;
          rx_byte  <= {sr, sdin_s};
          rx_dc    <= dc_s;
        end
      end else if (abort_hit) begin
        bitcnt <= '0;
      end
    end
  end

  parse_t state_q, state_d;
  logic   cmd_rdy;

  assign cmd_rdy = byte_rdy & ~rx_dc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: the default-first assignment keeps this block free of inferred latches.
    state_d = state_q;
    if (cmd_rdy) begin
      unique case (state_q)
        IDLE:    if (rx_byte == CMD_COL)      state_d = COL_S;
                 else if (rx_byte == CMD_ROW) state_d = ROW_S;
        COL_S:   state_d = COL_E;
        COL_E:   state_d = IDLE;
        ROW_S:   state_d = ROW_E;
        ROW_E:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  logic [6:0] col_arg, col_start, col_end, cur_x;
  logic [5:0] row_arg, row_start, row_end, cur_y;
  logic       byte_phase;
  logic [7:0] hi_byte;

  assign col_arg = (rx_byte > COL_MAX) ? COL_MAX[6:0] : rx_byte[6:0];
  assign row_arg = (rx_byte > ROW_MAX) ? ROW_MAX[5:0] : rx_byte[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_done  <= 1'b0;
      col_start   <= '0;
      col_end     <= COL_MAX[6:0];
      row_start   <= '0;
      row_end     <= ROW_MAX[5:0];
      cur_x       <= '0;
      cur_y       <= '0;
      byte_phase  <= 1'b0;
      hi_byte     <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (cmd_rdy) begin
        cmd_valid  <= 1'b1;
        cmd_byte   <= rx_byte;
        byte_phase <= 1'b0;
        case (state_q)
          COL_S: col_start <= col_arg;
          COL_E: begin col_end <= col_arg; cur_x <= col_start; end
          ROW_S: row_start <= row_arg;
          ROW_E: begin row_end <= row_arg; cur_y <= row_start; end
          default: ;
        endcase
      end else if (byte_rdy && !byte_phase) begin
        hi_byte    <= rx_byte;
        byte_phase <= 1'b1;
      end else if (byte_rdy) begin
        pixel_valid <= 1'b1;
        pixel_data  <= {hi_byte, rx_byte};
        pixel_x     <= cur_x;
        pixel_y     <= cur_y;
        byte_phase  <= 1'b0;
        // An inverted window on an axis pins the cursor to that axis' start.
        if (col_end < col_start) begin
          cur_x <= col_start;
        end else if (cur_x == col_end) begin
          cur_x <= col_start;
          if (row_end < row_start) begin
            cur_y <= row_start;
          end else if (cur_y == row_end) begin
            cur_y      <= row_start;
            frame_done <= 1'b1;
          end else begin
            cur_y <= cur_y + 6'd1;
          end
        end else begin
          cur_x <= cur_x + 7'd1;
        end
      end
    end
  end

`ifdef OLED_RX_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (abort_hit)  abort_cnt <= abort_cnt + 16'd1;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign abort_cnt = '0;
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Self-checking bench for oled_spi_receiver: table vectors, corner sequences and random traffic vs a window/cursor model.
`timescale 1ns/1ps
module tb_oled_spi_receiver;

  localparam int SYNC = 2;
`ifdef OLED_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic cs = 1'b1, cs_small = 1'b1, sclk = 1'b0, sdin = 1'b0, d_cn = 1'b0;

  logic        cmd_valid, pixel_valid, frame_done;
  logic [7:0]  cmd_byte;
  logic [15:0] pixel_data, abort_cnt, frame_cnt;
  logic [6:0]  pixel_x;
  logic [5:0]  pixel_y;

  logic        sm_cmd_valid, sm_pixel_valid, sm_frame_done;
  logic [7:0]  sm_cmd_byte;
  logic [15:0] sm_pixel_data, sm_abort_cnt, sm_frame_cnt;
  logic [6:0]  sm_pixel_x;
  logic [5:0]  sm_pixel_y;

  always #5 clk = ~clk;

  oled_spi_receiver #(.SYNC_STAGES(SYNC), .WIDTH(96), .HEIGHT(64)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .sclk(sclk), .sdin(sdin), .d_cn(d_cn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_done(frame_done), .abort_cnt(abort_cnt), .frame_cnt(frame_cnt)
  );

  // Scaled panel so a complete frame from reset fits in a short run.
  oled_spi_receiver #(.SYNC_STAGES(SYNC), .WIDTH(8), .HEIGHT(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .cs(cs_small), .sclk(sclk), .sdin(sdin), .d_cn(d_cn),
    .cmd_valid(sm_cmd_valid), .cmd_byte(sm_cmd_byte), .pixel_valid(sm_pixel_valid),
    .pixel_data(sm_pixel_data), .pixel_x(sm_pixel_x), .pixel_y(sm_pixel_y),
    .frame_done(sm_frame_done), .abort_cnt(sm_abort_cnt), .frame_cnt(sm_frame_cnt)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cs, m_ce, m_rs, m_re, m_x, m_y, m_phase, m_hi, m_args_left, m_abort, m_frames;
  bit m_axis_row;
  logic        e_cv, e_pv, e_fd;
  logic [7:0]  e_cb;
  logic [15:0] e_pd;
  int          e_px, e_py;

  task automatic model_reset();
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63; m_x = 0; m_y = 0;
    m_phase = 0; m_hi = 0; m_args_left = 0; m_axis_row = 0; m_abort = 0; m_frames = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    int v;
    e_cv = 0; e_pv = 0; e_fd = 0; e_cb = b; e_pd = '0; e_px = 0; e_py = 0;
    if (!dc) begin
      e_cv = 1; m_phase = 0;
      if (m_args_left > 0) begin
        v = m_axis_row ? ((int'(b) > 63) ? 63 : int'(b)) : ((int'(b) > 95) ? 95 : int'(b));
        if (m_args_left == 2) begin
          if (m_axis_row) m_rs = v; else m_cs = v;
        end else begin
          if (m_axis_row) begin m_re = v; m_y = m_rs; end
          else            begin m_ce = v; m_x = m_cs; end
        end
        m_args_left--;
      end else if (b == 8'h15) begin m_axis_row = 0; m_args_left = 2; end
      else if (b == 8'h75)     begin m_axis_row = 1; m_args_left = 2; end
    end else if (m_phase == 0) begin
      m_hi = int'(b); m_phase = 1;
    end else begin
      e_pv = 1; e_pd = {8'(m_hi), b}; e_px = m_x; e_py = m_y; m_phase = 0;
      if (m_ce < m_cs) m_x = m_cs;
      else if (m_x != m_ce) m_x = (m_x + 1) % 128;
      else begin
        m_x = m_cs;
        if (m_re < m_rs) m_y = m_rs;
        else if (m_y == m_re) begin m_y = m_rs; e_fd = 1; m_frames++; end
        else m_y = m_y + 1;
      end
    end
  endtask

  // ---------------- SPI driver / sampler ----------------
  logic        o_pre, o_cv, o_pv, o_fd, s_pv, s_fd;
  logic [7:0]  o_cb;
  logic [15:0] o_pd, s_pd;
  logic [6:0]  o_px, s_px;
  logic [5:0]  o_py, s_py;

  task automatic spi_bits(input logic [7:0] b, input logic dc, input int n, input int half);
    @(negedge clk);
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0; sdin = b[i]; d_cn = dc;
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      if (i != 8 - n) repeat (half) @(negedge clk);
    end
  endtask

  // Sends one byte, then samples outputs SYNC+1 and SYNC+2 clocks after the last rising sclk.
  task automatic spi_byte(input logic [7:0] b, input logic dc, input int half);
    spi_bits(b, dc, 8, half);
    repeat (SYNC + 1) @(posedge clk);
    #1 o_pre = cmd_valid | pixel_valid;
    @(posedge clk);
    #1;
    o_cv = cmd_valid; o_cb = cmd_byte; o_pv = pixel_valid; o_pd = pixel_data;
    o_px = pixel_x; o_py = pixel_y; o_fd = frame_done;
    s_pv = sm_pixel_valid; s_pd = sm_pixel_data; s_px = sm_pixel_x; s_py = sm_pixel_y;
    s_fd = sm_frame_done;
    @(negedge clk) sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_checked(input string name, input logic [7:0] b, input logic dc);
    model_byte(b, dc);
    spi_byte(b, dc, 4);
    check({name, ".cmd_valid"}, 32'(o_cv), 32'(e_cv));
    check({name, ".pixel_valid"}, 32'(o_pv), 32'(e_pv));
    check({name, ".frame_done"}, 32'(o_fd), 32'(e_fd));
    if (e_cv) check({name, ".cmd_byte"}, 32'(o_cb), 32'(e_cb));
    if (e_pv) begin
      check({name, ".pixel_data"}, 32'(o_pd), 32'(e_pd));
      check({name, ".pixel_x"}, 32'(o_px), 32'(e_px));
      check({name, ".pixel_y"}, 32'(o_py), 32'(e_py));
    end
  endtask

  task automatic abort_partial(input int n);
    spi_bits(8'hA5, 1'b1, n, 4);
    @(negedge clk) sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    m_abort++;
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b;
    logic        dc;
    logic        cv;
    logic        pv;
    logic [15:0] pd;
    logic [6:0]  px;
    logic [5:0]  py;
    logic        fd;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [7:0] b, input logic dc, input logic cv, input logic pv,
                              input logic [15:0] pd, input int px, input int py, input logic fd);
    vec_t t;
    t.b = b; t.dc = dc; t.cv = cv; t.pv = pv; t.pd = pd; t.px = 7'(px); t.py = 6'(py); t.fd = fd;
    return t;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] win_cmds[6];
    int xs[6], ys[6];
    logic [7:0] hb, lb, rb;
    int r;
    win_cmds = '{8'h15, 8'h10, 8'h12, 8'h75, 8'h05, 8'h06};
    xs = '{16, 17, 18, 16, 17, 18};
    ys = '{5, 5, 5, 6, 6, 6};
    for (int i = 0; i < 6; i++) tbl[i] = mk(win_cmds[i], 1'b0, 1'b1, 1'b0, 16'h0, 0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      hb = 8'(8'h30 + k);
      lb = 8'(8'hC0 + k);
      tbl[6 + 2 * k] = mk(hb, 1'b1, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0);
      tbl[7 + 2 * k] = mk(lb, 1'b1, 1'b0, 1'b1, {hb, lb}, xs[k], ys[k], k == 5);
    end

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.cmd_valid", 32'(cmd_valid), 0);
    check("rst.cmd_byte", 32'(cmd_byte), 0);
    check("rst.pixel_valid", 32'(pixel_valid), 0);
    check("rst.pixel_data", 32'(pixel_data), 0);
    check("rst.pixel_x", 32'(pixel_x), 0);
    check("rst.pixel_y", 32'(pixel_y), 0);
    check("rst.frame_done", 32'(frame_done), 0);
    check("rst.abort_cnt", 32'(abort_cnt), 0);
    check("rst.frame_cnt", 32'(frame_cnt), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-transfer
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'hAB, 1'b1, 4);
    spi_byte(8'hCD, 1'b1, 4);
    spi_bits(8'h5A, 1'b1, 5, 4);
    @(negedge clk) reset_n = 1'b0;
    #2;
    check("midrst.pixel_data", 32'(pixel_data), 0);
    check("midrst.pixel_valid", 32'(pixel_valid | cmd_valid | frame_done), 0);
    sclk = 1'b0; cs = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_checked("midrst.hi", 8'hF8, 1'b1);
    send_checked("midrst.lo", 8'h00, 1'b1);
    check("midrst.pix", 32'(pixel_data), 32'h0000F800);
    check("midrst.abort", 32'(abort_cnt), 0);

    // Latency at 3.125 MHz sclk
    model_byte(8'hAF, 1'b0);
    spi_byte(8'hAF, 1'b0, 16);
    check("lat.early", 32'(o_pre), 0);
    check("lat.cmd_valid", 32'(o_cv), 1);
    check("lat.cmd_byte", 32'(o_cb), 32'hAF);

    // Window table
    for (int i = 0; i < 18; i++) begin
      model_byte(tbl[i].b, tbl[i].dc);
      spi_byte(tbl[i].b, tbl[i].dc, 4);
      check($sformatf("tbl%0d.cmd_valid", i), 32'(o_cv), 32'(tbl[i].cv));
      check($sformatf("tbl%0d.pixel_valid", i), 32'(o_pv), 32'(tbl[i].pv));
      check($sformatf("tbl%0d.frame_done", i), 32'(o_fd), 32'(tbl[i].fd));
      if (tbl[i].cv) check($sformatf("tbl%0d.cmd_byte", i), 32'(o_cb), 32'(tbl[i].b));
      if (tbl[i].pv) begin
        check($sformatf("tbl%0d.pixel_data", i), 32'(o_pd), 32'(tbl[i].pd));
        check($sformatf("tbl%0d.pixel_x", i), 32'(o_px), 32'(tbl[i].px));
        check($sformatf("tbl%0d.pixel_y", i), 32'(o_py), 32'(tbl[i].py));
      end
    end

    // Full frame from reset on the 8x4 instance, plus the first pixel of the next frame
    cs = 1'b1;
    do_reset();
    cs_small = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 33; k++) begin
      spi_byte(8'(k), 1'b1, 4);
      spi_byte(8'(~k), 1'b1, 4);
      check($sformatf("frame%0d.pixel_valid", k), 32'(s_pv), 1);
      check($sformatf("frame%0d.pixel_data", k), 32'(s_pd), 32'({8'(k), 8'(~k)}));
      check($sformatf("frame%0d.pixel_x", k), 32'(s_px), 32'(k % 8));
      check($sformatf("frame%0d.pixel_y", k), 32'(s_py), 32'((k / 8) % 4));
      check($sformatf("frame%0d.frame_done", k), 32'(s_fd), 32'(k == 31));
    end
    cs_small = 1'b1;
    repeat (4) @(negedge clk);
    check("frame.frame_cnt", 32'(sm_frame_cnt), STATS ? 1 : 0);

    // Abort then a command byte
    cs = 1'b0;
    repeat (4) @(negedge clk);
    abort_partial(5);
    send_checked("abort.cmd", 8'h07, 1'b0);
    check("abort.cmd_byte", 32'(cmd_byte), 32'h07);
    check("abort.abort_cnt", 32'(abort_cnt), STATS ? 1 : 0);

    // Clamped, inverted column window
    send_checked("deg.c", 8'h15, 1'b0);
    send_checked("deg.s", 8'hFF, 1'b0);
    send_checked("deg.e", 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) send_checked("deg.px", 8'(8'h40 + k), 1'b1);
    check("deg.pixel_x", 32'(pixel_x), 95);

    // Window on the far panel edge with clamped end column
    send_checked("edge.c", 8'h15, 1'b0);
    send_checked("edge.cs", 8'd93, 1'b0);
    send_checked("edge.ce", 8'd200, 1'b0);
    send_checked("edge.r", 8'h75, 1'b0);
    send_checked("edge.rs", 8'd62, 1'b0);
    send_checked("edge.re", 8'd63, 1'b0);
    for (int k = 0; k < 14; k++) send_checked("edge.px", 8'($urandom), 1'b1);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        abort_partial($urandom_range(1, 7));
      end else if (r < 12) begin
        if ($urandom_range(0, 1) == 1) begin
          send_checked("rnd.col", 8'h15, 1'b0);
          send_checked("rnd.cs", 8'($urandom_range(85, 110)), 1'b0);
          send_checked("rnd.ce", 8'($urandom_range(88, 110)), 1'b0);
        end else begin
          send_checked("rnd.row", 8'h75, 1'b0);
          send_checked("rnd.rs", 8'($urandom_range(56, 70)), 1'b0);
          send_checked("rnd.re", 8'($urandom_range(58, 70)), 1'b0);
        end
      end else if (r < 20) begin
        rb = 8'($urandom);
        if (rb == 8'h15 || rb == 8'h75) rb = 8'hAF;
        send_checked("rnd.cmd", rb, 1'b0);
      end else begin
        send_checked("rnd.data", 8'($urandom), 1'b1);
      end
    end

    repeat (4) @(negedge clk);
    check("final.abort_cnt", 32'(abort_cnt), STATS ? 32'(16'(m_abort)) : 0);
    check("final.frame_cnt", 32'(frame_cnt), STATS ? 32'(16'(m_frames)) : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
